// File: rtl/kernel_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : kernel_mem_responder
//  Purpose  : Memory-side responder for the kernel host-memory interface.
//             Services single-word reads/writes from an internal scratchpad
//             and acknowledges each after a programmable latency.
//  Revision : 1.0  initial release
// ============================================================================
module kernel_mem_responder #(
  parameter int                  ADDR_WID  = 14,
  parameter int                  DATA_WID  = 32,
  parameter int                  READ_LAT  = 2,
  parameter int                  WRITE_LAT = 1,
  parameter logic [DATA_WID-1:0] FILL_WORD = 32'hDEADBEEF
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [63:0]         mem_base,
  input  logic                read_enable,
  input  logic [63:0]         read_addr,
  input  logic [63:0]         read_size,
  input  logic                finish_read,
  input  logic                write_enable,
  input  logic [63:0]         write_addr,
  input  logic [DATA_WID-1:0] write_data,
  input  logic [63:0]         write_size,
  input  logic                finish_write,
  output logic [63:0]         read_ready,
  output logic [DATA_WID-1:0] read_data,
  output logic [63:0]         write_ready,
  output logic                busy,
  output logic                err,
  output logic [31:0]         rd_count,
  output logic [31:0]         wr_count
);

  localparam int         DEPTH         = 1 << ADDR_WID;
  localparam logic [3:0] RD_CNT_INIT   = 4'(READ_LAT - 1);
  localparam logic [3:0] WR_CNT_INIT   = 4'(WRITE_LAT - 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_WAIT = 3'd1,
    ST_RD_RESP = 3'd2,
    ST_WR_WAIT = 3'd3,
    ST_WR_RESP = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [ADDR_WID-1:0]   idx_q, idx_d;
  logic                  oor_q, oor_d;
  logic [DATA_WID-1:0]   wdata_q, wdata_d;
  logic [DATA_WID-1:0]   rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic [31:0]           rd_count_q, rd_count_d;
  logic [31:0]           wr_count_q, wr_count_d;
  logic                  mem_we;
  logic [DATA_WID-1:0]   mem_q [0:DEPTH-1];

  // Request decode: a write wins when both enables arrive together.
  logic [63:0]           req_addr;
  logic [63:0]           req_off;
  logic                  req_oor;
  logic                  req_mis;
  logic [ADDR_WID-1:0]   req_idx;

  assign req_addr = write_enable ? write_addr : read_addr;
  assign req_off  = req_addr - mem_base;
  assign req_oor  = (req_addr < mem_base) || (|req_off[63:ADDR_WID+2]);
  assign req_mis  = |req_off[1:0];
  assign req_idx  = req_off[ADDR_WID+1:2];

  // Size and burst-end markers are informational only on this responder.
  logic unused_side_inputs;
  assign unused_side_inputs = ^{read_size, write_size, finish_read, finish_write};

  // Next-state, datapath and flag logic for the request FSM.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    oor_d      = oor_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    rd_count_d = rd_count_q;
    wr_count_d = wr_count_q;
    mem_we     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (write_enable) begin
          idx_d   = req_idx;
          oor_d   = req_oor;
          wdata_d = write_data;
          cnt_d   = WR_CNT_INIT;
          state_d = ST_WR_WAIT;
          // A simultaneous read is dropped and flagged.
          if (read_enable || req_mis) err_d = 1'b1;
        end else if (read_enable) begin
          idx_d   = req_idx;
          oor_d   = req_oor;
          cnt_d   = RD_CNT_INIT;
          state_d = ST_RD_WAIT;
          if (req_mis) err_d = 1'b1;
        end
      end
      ST_RD_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d    = ST_RD_RESP;
          rdata_d    = oor_q ? FILL_WORD : mem_q[idx_q];
          rd_count_d = rd_count_q + 32'd1;
          if (oor_q) err_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_WR_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d    = ST_WR_RESP;
          mem_we     = !oor_q;
          wr_count_d = wr_count_q + 32'd1;
          if (oor_q) err_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RD_RESP: state_d = ST_IDLE;
      ST_WR_RESP: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase

    // Requests arriving outside IDLE are overruns.
    if ((state_q != ST_IDLE) && (read_enable || write_enable)) err_d = 1'b1;
  end

  // State and datapath registers; reset discards any in-flight request.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 4'd0;
      idx_q      <= '0;
      oor_q      <= 1'b0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      rd_count_q <= 32'd0;
      wr_count_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      oor_q      <= oor_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
      rd_count_q <= rd_count_d;
      wr_count_q <= wr_count_d;
    end
  end

  // Scratchpad commit on the edge entering WR_RESP; contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[idx_q] <= wdata_q;
  end

  assign read_ready  = {63'd0, state_q == ST_RD_RESP};
  assign write_ready = {63'd0, state_q == ST_WR_RESP};
  assign read_data   = rdata_q;
  assign busy        = (state_q != ST_IDLE);
  assign err         = err_q;
  assign rd_count    = rd_count_q;
  assign wr_count    = wr_count_q;

endmodule
`default_nettype wire

// File: tb/tb_kernel_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_kernel_mem_responder
//  Purpose  : Self-checking bench for kernel_mem_responder (vector table,
//             directed corner sequences, randomized run against a model).
//  Revision : 1.0  initial release
// ============================================================================
module tb_kernel_mem_responder;

  localparam int WR_LAT   = 1;
  localparam int RD_LAT_S = 2;
  localparam int RD_LAT_F = 1;
  localparam logic [63:0] BASE = 64'h1000;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [63:0] mem_base, read_addr, read_size, write_addr, write_size;
  logic        read_enable, write_enable, finish_read, finish_write;
  logic [31:0] write_data;

  logic [63:0] rr0, wr0, rr1, wr1;
  logic [31:0] rd0, rd1, rc0, rc1, wc0, wc1;
  logic        busy0, busy1, err0, err1;

  // Selected-DUT view: fast=0 -> READ_LAT 2 instance, fast=1 -> READ_LAT 1.
  logic        fast;
  logic [63:0] rr_s, wr_s;
  logic [31:0] rd_s, rc_s, wc_s;
  logic        busy_s, err_s;
  assign rr_s   = fast ? rr1   : rr0;
  assign wr_s   = fast ? wr1   : wr0;
  assign rd_s   = fast ? rd1   : rd0;
  assign rc_s   = fast ? rc1   : rc0;
  assign wc_s   = fast ? wc1   : wc0;
  assign busy_s = fast ? busy1 : busy0;
  assign err_s  = fast ? err1  : err0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  kernel_mem_responder #(.READ_LAT(RD_LAT_S), .WRITE_LAT(WR_LAT)) dut (
    .clk(clk), .reset_n(reset_n), .mem_base(mem_base),
    .read_enable(read_enable), .read_addr(read_addr), .read_size(read_size),
    .finish_read(finish_read), .write_enable(write_enable),
    .write_addr(write_addr), .write_data(write_data), .write_size(write_size),
    .finish_write(finish_write), .read_ready(rr0), .read_data(rd0),
    .write_ready(wr0), .busy(busy0), .err(err0), .rd_count(rc0), .wr_count(wc0)
  );

  kernel_mem_responder #(.READ_LAT(RD_LAT_F), .WRITE_LAT(WR_LAT)) dut_fast (
    .clk(clk), .reset_n(reset_n), .mem_base(mem_base),
    .read_enable(read_enable), .read_addr(read_addr), .read_size(read_size),
    .finish_read(finish_read), .write_enable(write_enable),
    .write_addr(write_addr), .write_data(write_data), .write_size(write_size),
    .finish_write(finish_write), .read_ready(rr1), .read_data(rd1),
    .write_ready(wr1), .busy(busy1), .err(err1), .rd_count(rc1), .wr_count(wc1)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, " read_ready"},  rr_s,          64'd0);
    check({tag, " write_ready"}, wr_s,          64'd0);
    check({tag, " read_data"},   64'(rd_s),     64'd0);
    check({tag, " busy"},        64'(busy_s),   64'd0);
    check({tag, " err"},         64'(err_s),    64'd0);
    check({tag, " rd_count"},    64'(rc_s),     64'd0);
    check({tag, " wr_count"},    64'(wc_s),     64'd0);
  endtask

  // Called #1 after a rising edge with the DUT idle; returns #1 after the
  // edge that brings it back to IDLE. lat = -1 when no ready pulse appears.
  task automatic xact(input bit wr, input logic [63:0] addr, input logic [31:0] data,
                      output int lat, output logic [31:0] rdata);
    if (wr) begin
      write_enable = 1'b1; write_addr = addr; write_data = data;
    end else begin
      read_enable = 1'b1; read_addr = addr;
    end
    @(posedge clk); #1;
    write_enable = 1'b0; read_enable = 1'b0;
    lat = -1; rdata = 'x;
    for (int n = 0; n <= 20; n++) begin
      if ((wr ? wr_s : rr_s) == 64'd1) begin
        lat = n; rdata = rd_s;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  typedef struct {
    bit          wr;
    logic [63:0] addr;
    logic [31:0] wdata;
    int          exp_lat;
    logic [31:0] exp_rdata;
    bit          exp_err;
    int          exp_rd;
    int          exp_wr;
  } vec_t;

  vec_t vecs[8];

  logic [31:0] model [int];
  int          written[$];

  initial begin
    int          lat, nrd, nwr;
    logic [31:0] rdata, cap;

    vecs[0] = '{1'b1, BASE + 64'h8,     32'h1234, WR_LAT,   32'h0,        1'b0, 0, 1};
    vecs[1] = '{1'b0, BASE + 64'h8,     32'h0,    RD_LAT_S, 32'h1234,     1'b0, 1, 1};
    vecs[2] = '{1'b1, BASE,             32'h11,   WR_LAT,   32'h0,        1'b0, 1, 2};
    vecs[3] = '{1'b1, BASE + 64'hFFFC,  32'hA5A5, WR_LAT,   32'h0,        1'b0, 1, 3};
    vecs[4] = '{1'b0, BASE + 64'hFFFC,  32'h0,    RD_LAT_S, 32'hA5A5,     1'b0, 2, 3};
    vecs[5] = '{1'b0, BASE,             32'h0,    RD_LAT_S, 32'h11,       1'b0, 3, 3};
    vecs[6] = '{1'b0, BASE - 64'h4,     32'h0,    RD_LAT_S, 32'hDEADBEEF, 1'b1, 4, 3};
    vecs[7] = '{1'b0, BASE + 64'h10000, 32'h0,    RD_LAT_S, 32'hDEADBEEF, 1'b1, 5, 3};

    fast = 1'b0;
    reset_n = 1'b0; mem_base = BASE;
    read_enable = 1'b0; write_enable = 1'b0; finish_read = 1'b0; finish_write = 1'b0;
    read_addr = '0; write_addr = '0; write_data = '0;
    read_size = 64'd4; write_size = 64'd4;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Vector table: basic write/read, scratchpad boundaries, out-of-range.
    for (int i = 0; i < 8; i++) begin
      xact(vecs[i].wr, vecs[i].addr, vecs[i].wdata, lat, rdata);
      check($sformatf("vec%0d latency", i), 64'(lat), 64'(vecs[i].exp_lat));
      if (!vecs[i].wr) check($sformatf("vec%0d read_data", i), 64'(rdata), 64'(vecs[i].exp_rdata));
      check($sformatf("vec%0d err", i),      64'(err_s), 64'(vecs[i].exp_err));
      check($sformatf("vec%0d rd_count", i), 64'(rc_s),  64'(vecs[i].exp_rd));
      check($sformatf("vec%0d wr_count", i), 64'(wc_s),  64'(vecs[i].exp_wr));
    end

    // Simultaneous read and write: write serviced, read dropped, err set.
    apply_reset();
    check("both pre err", 64'(err_s), 64'd0);
    write_enable = 1'b1; write_addr = BASE + 64'h10; write_data = 32'd7;
    read_enable = 1'b1;  read_addr = BASE + 64'h14;
    @(posedge clk); #1;
    write_enable = 1'b0; read_enable = 1'b0;
    nrd = 0; nwr = 0;
    for (int n = 0; n < 8; n++) begin
      if (rr_s == 64'd1) nrd++;
      if (wr_s == 64'd1) nwr++;
      @(posedge clk); #1;
    end
    check("both write_ready pulses", 64'(nwr), 64'd1);
    check("both read_ready pulses",  64'(nrd), 64'd0);
    check("both err", 64'(err_s), 64'd1);
    xact(1'b0, BASE + 64'h10, 32'h0, lat, rdata);
    check("both mem[4]", 64'(rdata), 64'd7);

    // Overrun: second read while busy is ignored.
    apply_reset();
    check("overrun pre err", 64'(err_s), 64'd0);
    read_enable = 1'b1; read_addr = BASE + 64'h8;
    @(posedge clk); #1;
    read_enable = 1'b0;
    check("overrun busy", 64'(busy_s), 64'd1);
    read_enable = 1'b1; read_addr = BASE;
    @(posedge clk); #1;
    read_enable = 1'b0;
    nrd = 0; cap = '0;
    for (int n = 0; n < 8; n++) begin
      if (rr_s == 64'd1) begin nrd++; cap = rd_s; end
      @(posedge clk); #1;
    end
    check("overrun read_ready pulses", 64'(nrd), 64'd1);
    check("overrun read_data", 64'(cap), 64'h1234);
    check("overrun err", 64'(err_s), 64'd1);
    check("overrun rd_count", 64'(rc_s), 64'd1);

    // Reset one cycle before WR_RESP: write discarded, word 0 keeps 0x11.
    apply_reset();
    write_enable = 1'b1; write_addr = BASE; write_data = 32'h55;
    @(posedge clk); #1;
    write_enable = 1'b0;
    reset_n = 1'b0;
    #1;
    check_zero("mid-reset");
    @(posedge clk); #1;
    nwr = (wr_s == 64'd1) ? 1 : 0;
    check_zero("held-reset");
    reset_n = 1'b1;
    for (int n = 0; n < 6; n++) begin
      if (wr_s == 64'd1) nwr++;
      @(posedge clk); #1;
    end
    check("reset write_ready pulses", 64'(nwr), 64'd0);
    xact(1'b0, BASE, 32'h0, lat, rdata);
    check("reset word0 latency", 64'(lat), 64'(RD_LAT_S));
    check("reset word0 data", 64'(rdata), 64'h11);

    // Randomized alternating writes/reads on the READ_LAT=1 instance.
    fast = 1'b1;
    apply_reset();
    for (int i = 0; i < 100; i++) begin
      int idx;
      if (i % 2 == 0) begin
        idx = int'($urandom_range(0, 31));
        if (i % 10 == 0) idx = int'($urandom_range(16352, 16383));
        model[idx] = $urandom;
        written.push_back(idx);
        xact(1'b1, BASE + 64'(idx) * 64'd4, model[idx], lat, rdata);
        check($sformatf("rand%0d write latency", i), 64'(lat), 64'(WR_LAT));
      end else begin
        idx = written[$urandom_range(0, written.size() - 1)];
        xact(1'b0, BASE + 64'(idx) * 64'd4, 32'h0, lat, rdata);
        check($sformatf("rand%0d read latency", i), 64'(lat), 64'(RD_LAT_F));
        check($sformatf("rand%0d read_data idx %0d", i, idx), 64'(rdata), 64'(model[idx]));
      end
    end
    check("rand rd_count", 64'(rc_s), 64'd50);
    check("rand wr_count", 64'(wc_s), 64'd50);
    check("rand err", 64'(err_s), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, checks %0d", checks);
    $fatal(1);
  end

endmodule
`default_nettype wire
